instruction_fetch: RTL

Fetch stage that owns the program counter and drives `read_address` of `Instruction_memory`. It consumes that memory's registered 32-bit output and presents an aligned instruction/PC pair, with a valid flag, to the IF/ID boundary. It also handles downstream stall and redirect (branch/jump), and halts on illegal fetch addresses. It contains no instruction storage: stalls are absorbed by re-presenting the held address to the memory.

---
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/instruction_fetch.sv | 117 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Bundle of signals between the fetch stage, the instruction memory and the
// IF/ID boundary. The master side is the fetch stage itself.
interface instruction_fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] read_address;
  logic [31:0] imem_instruction;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        if_fault;

  modport master (
    input  stall, redirect, redirect_pc, imem_instruction,
    output read_address, if_instruction, if_pc, if_pc_plus4, if_valid, if_fault
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_instruction,
    input  read_address, if_instruction, if_pc, if_pc_plus4, if_valid, if_fault
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses a 1-cycle-latency instruction memory and
// presents instruction/PC pairs to IF/ID with stall, redirect and fault halt.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 256
) (
  input logic               clk,
  input logic               rst_n,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
  endfunction

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] if_pc_r, if_pc_nxt_s;
  logic [31:0] if_pc_plus4_r, if_pc_plus4_nxt_s;
  logic        if_valid_r, if_valid_nxt_s;
  logic        if_fault_r, if_fault_nxt_s;
  logic [31:0] addr_s;
  logic        issue_s;
  logic        legal_s;

  // Address select and issue decision; a stalled RUN re-reads the held word
  always_comb begin
    addr_s  = pc_r;
    issue_s = 1'b0;
    if (bus.redirect) begin
      addr_s  = bus.redirect_pc;
      issue_s = 1'b1;
    end else begin
      case (state_r)
        BOOT: begin
          addr_s  = pc_r;
          issue_s = 1'b1;
        end
        RUN: begin
          addr_s  = bus.stall ? if_pc_r : pc_r;
          issue_s = ~bus.stall;
        end
        HALT: begin
          addr_s  = if_pc_r;
          issue_s = 1'b0;
        end
        default: begin
          addr_s  = pc_r;
          issue_s = 1'b0;
        end
      endcase
    end
    legal_s = is_legal(addr_s);
  end

  // Next-state and next register values
  always_comb begin
    state_nxt_s       = state_r;
    pc_nxt_s          = pc_r;
    if_pc_nxt_s       = if_pc_r;
    if_pc_plus4_nxt_s = if_pc_plus4_r;
    if_valid_nxt_s    = if_valid_r;
    if_fault_nxt_s    = if_fault_r;
    if (issue_s) begin
      if (legal_s) begin
        if_pc_nxt_s       = addr_s;
        if_pc_plus4_nxt_s = addr_s + 32'd4;
        pc_nxt_s          = addr_s + 32'd4;
        if_valid_nxt_s    = 1'b1;
        if_fault_nxt_s    = 1'b0;
        state_nxt_s       = RUN;
      end else begin
        if_pc_nxt_s    = addr_s;
        if_valid_nxt_s = 1'b0;
        if_fault_nxt_s = 1'b1;
        state_nxt_s    = HALT;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= BOOT;
      pc_r          <= RESET_PC;
      if_pc_r       <= 32'h0000_0000;
      if_pc_plus4_r <= 32'h0000_0004;
      if_valid_r    <= 1'b0;
      if_fault_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      if_pc_r       <= if_pc_nxt_s;
      if_pc_plus4_r <= if_pc_plus4_nxt_s;
      if_valid_r    <= if_valid_nxt_s;
      if_fault_r    <= if_fault_nxt_s;
    end
  end

  assign bus.read_address   = addr_s;
  assign bus.if_instruction = bus.imem_instruction;
  assign bus.if_pc          = if_pc_r;
  assign bus.if_pc_plus4    = if_pc_plus4_r;
  assign bus.if_valid       = if_valid_r;
  assign bus.if_fault       = if_fault_r;

endmodule
